serial_complement2: RTL and testbench
=====================================

SERIAL_COMPLEMENT2 -- requirements
Module: serial_complement2

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 mode  input  2  operation select: 00 pass, 01 negate (two's complement), 10 absolute value, 11 one's complement.
REQ-006 a  input  WIDTH  operand, two's-complement signed.
REQ-007 busy  output  1  high while an operation is in progress (SHIFT state).
REQ-008 done  output  1  single-cycle pulse marking result valid.
REQ-009 result  output  WIDTH  operation result; held stable from done until the next accepted start.
REQ-010 overflow  output  1  result not representable; valid with done, held with result.

Function
REQ-011 FSM states: IDLE, SHIFT, DONE; SHIFT uses a bit counter 0..WIDTH-1.
REQ-012 IDLE: start=1 at an edge latches a and mode, clears the internal seen-one flag and counter, and moves to SHIFT.
REQ-013 Start is ignored in SHIFT and DONE; a, mode changes after acceptance do not affect the running operation.
REQ-014 SHIFT processes one operand bit per cycle, LSB first; the output bit shifts into result MSB, result shifting right, so after WIDTH bits result[0] holds processed bit 0.
REQ-015 Per-bit rule, operand bit b: pass -> b; one's complement -> ~b; negate -> (seen_one ? ~b : b), then seen_one |= b.
REQ-016 Absolute value applies the negate rule when latched a[WIDTH-1]=1, otherwise the pass rule.
REQ-017 After the WIDTH-th SHIFT edge, state goes to DONE; done=1 and busy=0 for exactly that one cycle; the next edge returns to IDLE.
REQ-018 Latency: start accepted at edge k -> busy high cycles k+1..k+WIDTH, done high in cycle after edge k+WIDTH.
REQ-019 overflow=1 only when mode is 01 or 10 and latched a equals 1 followed by WIDTH-1 zeros; result then equals that same pattern.
REQ-020 Negate of zero yields zero with overflow=0; no carry-out is reported.
REQ-021 All arithmetic is modulo 2^WIDTH; no output wider than WIDTH.
REQ-022 busy and done are never high in the same cycle.

Reset
REQ-023 reset=1 at an edge forces IDLE, clears counter and seen-one flag, and sets busy=0, done=0, overflow=0, result=0.
REQ-024 reset has priority over start and over any in-progress SHIFT; the aborted operation produces no done pulse.
REQ-025 After reset deasserts, the first start in IDLE is accepted normally.

Verification (WIDTH=5)
REQ-026 mode=01, a=00111, start 1 cycle -> busy high 5 cycles, then done=1, result=11001, overflow=0.
REQ-027 mode=01, a=01010 -> result=10110; mode=01, a=01111 -> result=10001; mode=11, a=01111 -> result=10000.
REQ-028 mode=10, a=10110 -> result=01010; mode=10, a=00110 -> result=00110; overflow=0 both.
REQ-029 mode=01, a=10000 -> result=10000, overflow=1; mode=01, a=00000 -> result=00000, overflow=0.
REQ-030 start asserted again during SHIFT with a different a -> ignored; single done with the original result.
REQ-031 reset asserted on 3rd SHIFT cycle -> next cycle busy=0, done=0, result=00000, no done pulse follows; subsequent start completes correctly.

Source files
------------

// File: rtl/serial_complement2.sv
// Bit-serial two's-complement unit: pass, negate, absolute value or one's complement,
// one operand bit per cycle LSB first, with a registered done pulse and overflow flag.
module serial_complement2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic in_bit, out_bit, neg_rule, arith_mode;

  always_comb begin
    arith_mode = (mode_q == 2'b01) || (mode_q == 2'b10);
    // Absolute value behaves as negate only for negative operands.
    neg_rule   = (mode_q == 2'b01) || ((mode_q == 2'b10) && a_q[WIDTH-1]);
    in_bit     = a_q[cnt_q];
    case (mode_q)
      2'b00:   out_bit = in_bit;
      2'b11:   out_bit = ~in_bit;
      default: out_bit = (neg_rule && seen_q) ? ~in_bit : in_bit;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    mode_d   = mode_q;
    a_d      = a_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          mode_d  = mode;
          seen_d  = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        result_d = {out_bit, result_q[WIDTH-1:1]};
        seen_d   = seen_q | in_bit;
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          ovf_d   = arith_mode && (a_q == MIN_NEG);
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      mode_q   <= 2'b00;
      a_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_complement2.sv
// Scoreboard bench for serial_complement2 at WIDTH=5: stimulus pushes expected
// {overflow,result}, an independent monitor pops and compares on every done pulse.
module tb_serial_complement2;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic         busy, done, overflow;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  int bcnt    = 0;
  logic [W:0] exp_q[$];

  serial_complement2 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0;
    end else begin
      if (busy && done) begin
        n_tests++; n_fail++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b", busy, done);
      end
      if (busy) bcnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: result=%b overflow=%0b", result, overflow);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("result", int'(result), int'(e[W-1:0]));
          check("overflow", int'(overflow), int'(e[W]));
          check("busy_cycles", bcnt, W);
        end
        bcnt = 0;
      end
    end
  end

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: done=0 expected 1", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [1:0] m, input logic [W-1:0] av,
                        input logic [W-1:0] er, input logic eo);
    exp_q.push_back({eo, er});
    start = 1'b1; mode = m; a = av;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the running op must not see them.
    start = 1'b0; mode = 2'($urandom); a = W'($urandom);
    wait_done("op");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; a = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(2'b01, 5'b00111, 5'b11001, 1'b0);
    run_op(2'b01, 5'b01010, 5'b10110, 1'b0);
    run_op(2'b01, 5'b01111, 5'b10001, 1'b0);
    run_op(2'b11, 5'b01111, 5'b10000, 1'b0);
    run_op(2'b10, 5'b10110, 5'b01010, 1'b0);
    run_op(2'b10, 5'b00110, 5'b00110, 1'b0);
    run_op(2'b01, 5'b10000, 5'b10000, 1'b1);
    run_op(2'b01, 5'b00000, 5'b00000, 1'b0);
    run_op(2'b00, 5'b10101, 5'b10101, 1'b0);
    run_op(2'b10, 5'b10000, 5'b10000, 1'b1);
    run_op(2'b11, 5'b10000, 5'b01111, 1'b0);
    run_op(2'b10, 5'b11111, 5'b00001, 1'b0);

    // Result holds after done until the next accepted start.
    repeat (3) @(posedge clk);
    #1;
    check("result_hold", int'(result), int'(5'b00001));

    // Second start during SHIFT must be ignored.
    exp_q.push_back({1'b0, 5'b11111});
    start = 1'b1; mode = 2'b01; a = 5'b00001;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b11; a = 5'b00110;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("restart_ignored");
    repeat (8) @(posedge clk);
    #1;

    // Reset on the 3rd SHIFT cycle aborts the op with no done pulse.
    exp_q.push_back({1'b0, 5'b11001});
    start = 1'b1; mode = 2'b01; a = 5'b00111;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_overflow", int'(overflow), 0);
    repeat (8) @(posedge clk);
    #1;

    run_op(2'b01, 5'b00011, 5'b11101, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
